// File: rtl/parity_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : parity_uart_rx                                               |
// | Description : Serial receiver for start/data/parity/stop frames. Samples   |
// |               each bit at its midpoint, checks parity with an XOR          |
// |               accumulator, flags framing errors and strobes valid for one  |
// |               cycle per completed frame.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module parity_uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
  localparam logic             C_PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_DONE      = 3'd5,
    S_WAIT_HIGH = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 acc_q, acc_d;
  logic                 pbit_q, pbit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rxs;

  // Two-stage synchronizer; the line idles high so both stages reset to 1.
  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  assign rxs = sync_q[1];

  // Frame sequencing: counter paces each bit, samples land on bit midpoints.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    pbit_d  = pbit_q;
    shift_d = shift_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == C_CNT_MID) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = S_DATA;
            idx_d   = '0;
            acc_d   = 1'b0;
          end else begin
            // Line went back high before the midpoint: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d = '0;
          acc_d = acc_q ^ rxs;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shift_d[i] = rxs;
            end
          end
          if (idx_q == C_IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + C_IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_PARITY: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          pbit_d  = rxs;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          data_d  = shift_q;
          perr_d  = (acc_q ^ pbit_q) != C_PAR_ODD;
          ferr_d  = ~rxs;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_DONE: begin
        cnt_d = '0;
        // A low stop bit may be the start of a break; wait for the line
        // to recover so one break yields exactly one errored frame.
        state_d = ferr_q ? S_WAIT_HIGH : S_IDLE;
      end

      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      pbit_q  <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      pbit_q  <= pbit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign valid      = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_parity_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_parity_uart_rx                                            |
// | Description : Self-checking bench for parity_uart_rx. Drives an even- and  |
// |               an odd-parity receiver from one serial line and compares    |
// |               every received frame against a frame-level model.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_parity_uart_rx;

  localparam int D = 8;
  localparam int C = 16;
  // rx edge to rxs (2) plus start detection to valid.
  localparam int LAT = 2 + C / 2 + (D + 2) * C + 1;
  localparam int MAXF = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx;
  logic [D-1:0] data_e, data_o;
  logic         valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected frames, pushed by the driver when the start bit begins.
  logic [D-1:0] exp_data [MAXF];
  bit           exp_pbit [MAXF];
  bit           exp_stop [MAXF];
  int           exp_fall [MAXF];
  int           vcyc_e   [MAXF];
  int           wr = 0, rd_e = 0, rd_o = 0;

  always #5 clk = ~clk;

  // Free-running cycle count used to time valid pulses.
  always @(posedge clk) cyc <= cyc + 1;

  parity_uart_rx #(.DATA_BITS(D), .CLKS_PER_BIT(C), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_e), .valid(valid_e),
    .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e)
  );

  parity_uart_rx #(.DATA_BITS(D), .CLKS_PER_BIT(C), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_o), .valid(valid_o),
    .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: parity error when total ones (data + parity bit) has the wrong sense.
  task automatic check_frame(input bit odd, input int i, input logic [D-1:0] d,
                             input logic pe, input logic fe);
    int  ones;
    bit  want_pe;
    ones    = $countones(exp_data[i]) + int'(exp_pbit[i]);
    want_pe = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    check(odd ? "data_o" : "data_e", 32'(d), 32'(exp_data[i]));
    check(odd ? "perr_o" : "perr_e", 32'(pe), 32'(want_pe));
    check(odd ? "ferr_o" : "ferr_e", 32'(fe), 32'(!exp_stop[i]));
    check(odd ? "lat_o" : "lat_e", 32'(cyc - exp_fall[i]), 32'(LAT));
  endtask

  // Scoreboard for the even-parity receiver.
  always @(negedge clk) begin
    if (valid_e === 1'b1) begin
      if (rd_e >= wr) begin
        check("extra_valid_e", 32'd1, 32'd0);
      end else begin
        vcyc_e[rd_e] = cyc;
        check_frame(1'b0, rd_e, data_e, perr_e, ferr_e);
        rd_e++;
      end
    end
  end

  // Scoreboard for the odd-parity receiver.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (rd_o >= wr) begin
        check("extra_valid_o", 32'd1, 32'd0);
      end else begin
        check_frame(1'b1, rd_o, data_o, perr_o, ferr_o);
        rd_o++;
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [D-1:0] d, input bit pbit, input bit stop);
    exp_data[wr] = d;
    exp_pbit[wr] = pbit;
    exp_stop[wr] = stop;
    exp_fall[wr] = cyc;
    wr++;
    drive_bit(1'b0);
    for (int i = 0; i < D; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_e), 32'd0);
    check("rst_busy", 32'(busy_e), 32'd0);
    check("rst_data", 32'(data_e), 32'd0);
    check("rst_perr", 32'(perr_o), 32'd0);
    check("rst_ferr", 32'(ferr_e), 32'd0);
    rst_n = 1'b1;
    repeat (C) @(negedge clk);

    // 0xA5 with correct even parity, then with the parity bit flipped.
    send_frame(8'hA5, 1'b0, 1'b1);
    drive_bit(1'b1);
    check("a5_data", 32'(data_e), 32'hA5);
    check("a5_p0_perr_e", 32'(perr_e), 32'd0);
    check("a5_p0_perr_o", 32'(perr_o), 32'd1);
    send_frame(8'hA5, 1'b1, 1'b1);
    drive_bit(1'b1);
    check("a5_p1_perr_e", 32'(perr_e), 32'd1);
    check("a5_p1_perr_o", 32'(perr_o), 32'd0);

    // Low stop bit followed by a 40-bit break: one errored frame only.
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * C) @(negedge clk);
    check("break_busy", 32'(busy_e), 32'd1);
    check("break_ferr", 32'(ferr_e), 32'd1);
    check("break_count", 32'(rd_e), 32'(wr));
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("break_idle", 32'(busy_e), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1);

    // Three-cycle glitch: START entered, then abandoned at the midpoint.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_hi", 32'(busy_e), 32'd1);
    repeat (C) @(negedge clk);
    check("glitch_busy_lo", 32'(busy_e), 32'd0);

    // Reset in the middle of data bit 4 of 0xFF; partial frame is dropped.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy_e), 32'd0);
    check("mid_rst_data", 32'(data_e), 32'd0);
    check("mid_rst_valid", 32'(valid_e), 32'd0);
    rst_n = 1'b1;
    repeat (2 * C) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1);
    drive_bit(1'b1);
    check("post_rst_data", 32'(data_e), 32'h81);

    // Back-to-back frames: valids are one whole frame (start+data+parity+stop) apart.
    k = wr;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    drive_bit(1'b1);
    check("b2b_count", 32'(rd_e), 32'(k + 2));
    check("b2b_gap", 32'(vcyc_e[k + 1] - vcyc_e[k]), 32'((D + 3) * C));

    // Randomized frames with random gaps and occasional framing errors.
    for (int n = 0; n < 40; n++) begin
      logic [D-1:0] d;
      bit           p, s;
      d = D'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s);
      if (!s) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 5) * C) @(negedge clk);
        drive_bit(1'b1);
      end
      repeat ($urandom_range(0, 3)) drive_bit(1'b1);
    end

    drive_bit(1'b1);
    repeat (4 * C) @(negedge clk);
    check("total_e", 32'(rd_e), 32'(wr));
    check("total_o", 32'(rd_o), 32'(wr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
